// File: rtl/logic_unit_pkg.sv
// Shared constants for the arbitrated bitwise logic unit: opcode encodings and
// the two output-stage states.
package logic_unit_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Output register state: EMPTY means rsp_valid is low.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/logic_unit.sv
// Combinational two-operand bitwise logic unit (OR/AND/XOR/NOR), WIDTH bits wide.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic unit among N_REQ requesters, with a one-deep
// registered, tagged valid/ready response stage.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ*2-1:0]         req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
);

  localparam int ID_W = $clog2(N_REQ);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] a_arr   [N_REQ];
  logic [WIDTH-1:0] b_arr   [N_REQ];
  logic [1:0]       op_arr  [N_REQ];
  logic [ID_W-1:0]  rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_valid;

  logic [ID_W-1:0]  grant_idx;
  logic             any_valid;
  logic             accept;
  logic             fire;
  logic [WIDTH-1:0] unit_y;

  // rot_idx[k] is the requester k positions after ptr, wrapping at N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [ID_W:0] sum;

    assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
    assign op_arr[gi] = req_op[gi*2 +: 2];

    assign sum          = {1'b0, ptr_q} + (ID_W+1)'(gi);
    assign rot_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                    : sum[ID_W-1:0];
    assign rot_valid[gi] = req_valid[rot_idx[gi]];

    assign req_ready[gi] = fire && (grant_idx == ID_W'(gi));
  end

  // Scanning from the far end lets the nearest valid requester overwrite the rest.
  always_comb begin
    grant_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_idx = rot_idx[k];
      end
    end
  end

  assign any_valid = |req_valid;
  assign accept    = (state_q == ST_EMPTY) || rsp_ready;
  assign fire      = rst_n && accept && any_valid;

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .a  (a_arr[grant_idx]),
    .b  (b_arr[grant_idx]),
    .op (op_arr[grant_idx]),
    .y  (unit_y)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (fire) begin
      state_d = ST_FULL;
      y_d     = unit_y;
      id_d    = grant_idx;
      ptr_d   = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_ready) begin
      // Drained with nothing to refill: data is kept, only valid drops.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a behavioural round-robin model pushes
// expected responses, a separate monitor compares them as the DUT presents results.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH-1:0]   req_a;
  logic [N_REQ*WIDTH-1:0]   req_b;
  logic [N_REQ*2-1:0]       req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_y;
  logic [ID_W-1:0]          rsp_id;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [ID_W-1:0]  id;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t model_last;
  bit   model_full;
  int   model_ptr;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // First valid requester at or after the pointer, going round; -1 if none.
  function automatic int pick();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (model_ptr + k) % N_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [1:0] op);
    req_valid[i]               = v;
    req_a[i*WIDTH +: WIDTH]    = a;
    req_b[i*WIDTH +: WIDTH]    = b;
    req_op[i*2 +: 2]           = op;
  endtask

  task automatic model_reset();
    model_full = 1'b0;
    model_ptr  = 0;
    model_last = '0;
    exp_q.delete();
  endtask

  // One clock: check handshake outputs against the model, then advance it.
  task automatic cycle();
    logic [N_REQ-1:0] exp_ready;
    bit               acc;
    int               g;
    rsp_t             r;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(model_full));
    acc       = !model_full || rsp_ready;
    g         = pick();
    exp_ready = '0;
    r         = '0;
    if (acc && g >= 0) begin
      exp_ready[g] = 1'b1;
      r.y  = ref_op(req_op[g*2 +: 2], req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
      r.id = ID_W'(g);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (acc && g >= 0) begin
      exp_q.push_back(r);
      model_last = r;
      model_full = 1'b1;
      model_ptr  = (g + 1) % N_REQ;
    end else if (rsp_ready) begin
      model_full = 1'b0;
    end
    #1;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, 1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
    end
  endtask

  // Monitor: a presented result must equal the queue head; it leaves on rsp_ready.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=y:%0h id:%0d required=no response t=%0t",
                 rsp_y, rsp_id, $time);
      end else begin
        chk("rsp_y", 32'(rsp_y), 32'(exp_q[0].y));
        chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    model_reset();

    // Reset with every requester asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_y", 32'(rsp_y), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;

    // Single request, then a NOR from another requester.
    set_req(1, 1'b1, 8'hF0, 8'h0F, OP_OR);
    cycle();
    chk("single_or_y", 32'(rsp_y), 32'hFF);
    chk("single_or_id", 32'(rsp_id), 32'd1);
    set_req(1, 1'b0, 8'h00, 8'h00, OP_OR);
    set_req(3, 1'b1, 8'hF0, 8'h0F, OP_NOR);
    cycle();
    chk("single_nor_y", 32'(rsp_y), 32'h00);
    chk("single_nor_id", 32'(rsp_id), 32'd3);

    // All valid: after requester 3 the rotation restarts at 0.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N_REQ; i++)
        set_req(i, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
      cycle();
      chk("rr_id", 32'(rsp_id), 32'(k % N_REQ));
    end

    // Backpressure with only requester 2 waiting.
    req_valid = '0;
    set_req(2, 1'b1, 8'h3C, 8'hC3, OP_XOR);
    rsp_ready = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h4);
    cycle();
    chk("bp_grant_y", 32'(rsp_y), 32'hFF);
    chk("bp_grant_id", 32'(rsp_id), 32'd2);

    // Mixed ops: pointer sits at 3, so requester 3 goes first.
    req_valid = '0;
    set_req(0, 1'b1, 8'hAA, 8'h0F, OP_AND);
    set_req(3, 1'b1, 8'hAA, 8'hFF, OP_XOR);
    cycle();
    chk("mixed_xor_y", 32'(rsp_y), 32'h55);
    chk("mixed_xor_id", 32'(rsp_id), 32'd3);
    cycle();
    chk("mixed_and_y", 32'(rsp_y), 32'h0A);
    chk("mixed_and_id", 32'(rsp_id), 32'd0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      randomize_reqs();
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Mid-operation reset while a result is held.
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0110;
    cycle();
    chk("midrst_first_id", 32'(rsp_id), 32'd1);

    for (int k = 0; k < 200; k++) begin
      randomize_reqs();
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Drain: valid drops, data keeps its last value.
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("drain_hold_y", 32'(rsp_y), 32'(model_last.y));
    chk("drain_hold_id", 32'(rsp_id), 32'(model_last.id));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
